// File: rtl/dot_product_package_feeder_pkg.sv
// Shared types and constants for the dot-product package feeder.
// The FSM state encoding lives here so that the top and any debug logic agree on it.
package dot_product_package_feeder_pkg;

  localparam int unsigned ELEMENT_WIDTH = 32;
  localparam int unsigned NO_OF_UNITS   = 8;
  localparam int unsigned TOTAL_W       = 32;
  localparam int unsigned ROWS_W        = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRowRst,
    StIssue,
    StCapture,
    StPresent,
    StWaitRdy,
    StWaitFin,
    StDone
  } feeder_state_e;

  // ceil(total / n); the extra bit keeps total near 2^32 from overflowing.
  function automatic logic [TOTAL_W-1:0] pkg_count(input logic [TOTAL_W-1:0] total,
                                                   input int unsigned n);
    logic [TOTAL_W:0] sum;
    sum = {1'b0, total} + (TOTAL_W + 1)'(n - 1);
    return TOTAL_W'(sum / (TOTAL_W + 1)'(n));
  endfunction

endpackage

// File: rtl/dot_product_package_feeder_tail_mask.sv
// Keep-mask for one package: the first valid_count_i elements (element 0 in the MSBs)
// are kept, the remaining element slots are forced to zero.
module package_tail_mask #(
  parameter int unsigned ElementWidth = 32,
  parameter int unsigned NoOfUnits    = 8
) (
  input  logic [$clog2(NoOfUnits+1)-1:0]   valid_count_i,
  output logic [ElementWidth*NoOfUnits-1:0] keep_mask_o
);

  always_comb begin
    keep_mask_o = '0;
    for (int unsigned k = 0; k < NoOfUnits; k++) begin
      if (k < 32'(valid_count_i)) begin
        keep_mask_o[ElementWidth*(NoOfUnits-k)-1 -: ElementWidth] = '1;
      end
    end
  end

endmodule

// File: rtl/dot_product_package_feeder.sv
// Feeds matrix-row and vector packages from two synchronous RAMs into the dot-product
// engine, one package per read_now/dp_ready handshake, row after row.
module dot_product_package_feeder
  import dot_product_package_feeder_pkg::*;
#(
  parameter int unsigned ElementWidth = ELEMENT_WIDTH,
  parameter int unsigned NoOfUnits    = NO_OF_UNITS,
  parameter int unsigned AddrW        = 16,
  parameter int unsigned ReadyTimeout = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_i,
  input  logic [TOTAL_W-1:0]                total_i,
  input  logic [ROWS_W-1:0]                 num_rows_i,
  input  logic [AddrW-1:0]                  row_base_addr_i,
  input  logic [AddrW-1:0]                  vec_base_addr_i,
  output logic                              row_mem_rd_en_o,
  output logic [AddrW-1:0]                  row_mem_addr_o,
  input  logic [ElementWidth*NoOfUnits-1:0] row_mem_rdata_i,
  output logic                              vec_mem_rd_en_o,
  output logic [AddrW-1:0]                  vec_mem_addr_o,
  input  logic [ElementWidth*NoOfUnits-1:0] vec_mem_rdata_i,
  output logic [ElementWidth*NoOfUnits-1:0] first_row_out_o,
  output logic [ElementWidth*NoOfUnits-1:0] second_row_out_o,
  output logic                              read_now_o,
  input  logic                              dp_ready_i,
  input  logic                              dp_finish_i,
  output logic                              dp_reset_o,
  output logic                              busy_o,
  output logic [ROWS_W-1:0]                 row_index_o,
  output logic                              done_o,
  output logic                              error_o
);

  localparam int unsigned DataW = ElementWidth * NoOfUnits;
  localparam int unsigned VcW   = $clog2(NoOfUnits + 1);
  localparam int unsigned TmoW  = $clog2(ReadyTimeout + 1);

  feeder_state_e       state_q, state_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic [TOTAL_W-1:0]  pkgs_q, pkgs_d;
  logic [TOTAL_W-1:0]  pkg_q, pkg_d;
  logic [TOTAL_W-1:0]  rem_q, rem_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic [ROWS_W-1:0]   row_q, row_d;
  logic [AddrW-1:0]    row_addr_q, row_addr_d;
  logic [AddrW-1:0]    vec_base_q, vec_base_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                error_q, error_d;
  logic [DataW-1:0]    row_out_q, row_out_d;
  logic [DataW-1:0]    vec_out_q, vec_out_d;

  logic [VcW-1:0]      valid_count;
  logic [DataW-1:0]    keep_mask;

  // rem_q holds the elements still unsent in this row, so it is only below N in the tail.
  assign valid_count = (rem_q >= TOTAL_W'(NoOfUnits)) ? VcW'(NoOfUnits) : VcW'(rem_q);

  package_tail_mask #(
    .ElementWidth (ElementWidth),
    .NoOfUnits    (NoOfUnits)
  ) u_tail_mask (
    .valid_count_i (valid_count),
    .keep_mask_o   (keep_mask)
  );

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    pkgs_d     = pkgs_q;
    pkg_d      = pkg_q;
    rem_d      = rem_q;
    rows_d     = rows_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    vec_base_d = vec_base_q;
    tmo_d      = '0;
    error_d    = error_q;
    row_out_d  = row_out_q;
    vec_out_d  = vec_out_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          error_d    = 1'b0;
          total_d    = total_i;
          rows_d     = num_rows_i;
          pkgs_d     = pkg_count(total_i, NoOfUnits);
          row_addr_d = row_base_addr_i;
          vec_base_d = vec_base_addr_i;
          row_d      = '0;
          pkg_d      = '0;
          state_d    = (total_i == '0 || num_rows_i == '0) ? StDone : StRowRst;
        end
      end
      StRowRst: begin
        pkg_d   = '0;
        rem_d   = total_q;
        state_d = StIssue;
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        row_out_d = row_mem_rdata_i & keep_mask;
        vec_out_d = vec_mem_rdata_i & keep_mask;
        state_d   = StPresent;
      end
      StPresent: state_d = StWaitRdy;
      StWaitRdy: begin
        if (dp_ready_i) begin
          // Rows are stored back to back, so the row address simply keeps counting.
          row_addr_d = row_addr_q + AddrW'(1);
          if (pkg_q == pkgs_q - TOTAL_W'(1)) begin
            state_d = StWaitFin;
          end else begin
            pkg_d   = pkg_q + TOTAL_W'(1);
            rem_d   = rem_q - TOTAL_W'(NoOfUnits);
            state_d = StIssue;
          end
        end else if (tmo_q == TmoW'(ReadyTimeout - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitFin: begin
        if (dp_finish_i) begin
          if (row_q == rows_q - ROWS_W'(1)) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + ROWS_W'(1);
            state_d = StRowRst;
          end
        end else if (tmo_q == TmoW'(ReadyTimeout - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      pkgs_q     <= '0;
      pkg_q      <= '0;
      rem_q      <= '0;
      rows_q     <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
      vec_base_q <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      row_out_q  <= '0;
      vec_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      pkgs_q     <= pkgs_d;
      pkg_q      <= pkg_d;
      rem_q      <= rem_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      row_addr_q <= row_addr_d;
      vec_base_q <= vec_base_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      row_out_q  <= row_out_d;
      vec_out_q  <= vec_out_d;
    end
  end

  assign row_mem_rd_en_o  = (state_q == StIssue);
  assign vec_mem_rd_en_o  = (state_q == StIssue);
  assign row_mem_addr_o   = row_addr_q;
  assign vec_mem_addr_o   = vec_base_q + pkg_q[AddrW-1:0];
  assign first_row_out_o  = row_out_q;
  assign second_row_out_o = vec_out_q;
  assign read_now_o       = (state_q == StPresent);
  assign dp_reset_o       = (state_q == StRowRst);
  assign done_o           = (state_q == StDone);
  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign row_index_o      = row_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_dot_product_package_feeder.sv
// Randomized bench: behavioural RAMs and engine, expected packages computed from the
// row/vector address rules and the tail-zeroing rule.
module tb_dot_product_package_feeder;

  localparam int unsigned W   = 32;
  localparam int unsigned N   = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned TMO = 64;
  localparam int unsigned DW  = W * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [31:0]   total_i;
  logic [15:0]   num_rows_i;
  logic [AW-1:0] row_base_i, vec_base_i;
  logic          row_rd_en, vec_rd_en;
  logic [AW-1:0] row_addr, vec_addr;
  logic [DW-1:0] row_rdata, vec_rdata;
  logic [DW-1:0] first_out, second_out;
  logic          read_now, dp_ready_i, dp_finish_i, dp_reset, busy, done, error;
  logic [15:0]   row_index;

  int checks   = 0;
  int failures = 0;
  int unsigned salt_r, salt_v;

  always #5 clk = ~clk;

  dot_product_package_feeder #(
    .ElementWidth (W),
    .NoOfUnits    (N),
    .AddrW        (AW),
    .ReadyTimeout (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .total_i          (total_i),
    .num_rows_i       (num_rows_i),
    .row_base_addr_i  (row_base_i),
    .vec_base_addr_i  (vec_base_i),
    .row_mem_rd_en_o  (row_rd_en),
    .row_mem_addr_o   (row_addr),
    .row_mem_rdata_i  (row_rdata),
    .vec_mem_rd_en_o  (vec_rd_en),
    .vec_mem_addr_o   (vec_addr),
    .vec_mem_rdata_i  (vec_rdata),
    .first_row_out_o  (first_out),
    .second_row_out_o (second_out),
    .read_now_o       (read_now),
    .dp_ready_i       (dp_ready_i),
    .dp_finish_i      (dp_finish_i),
    .dp_reset_o       (dp_reset),
    .busy_o           (busy),
    .row_index_o      (row_index),
    .done_o           (done),
    .error_o          (error)
  );

  // Memory contents are a function of address and a per-job salt; every element is nonzero.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int unsigned salt);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[W*(N-k)-1 -: W] = {a, 4'hA, 4'(k), 8'(salt)};
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_pkg(input logic [DW-1:0] w, input int unsigned total,
                                            input int unsigned p);
    logic [DW-1:0] r;
    r = w;
    for (int k = 0; k < N; k++) if (p * N + k >= total) r[W*(N-k)-1 -: W] = '0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (row_rd_en) row_rdata <= mem_word(row_addr, salt_r);
    if (vec_rd_en) vec_rdata <= mem_word(vec_addr, salt_v);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int unsigned total, input int unsigned rows,
                         input logic [AW-1:0] rbase, input logic [AW-1:0] vbase,
                         input int unsigned max_dly, input bit spurious, input bit no_ready);
    int unsigned pkgs, pk, n_exp, n_rd, n_rn, n_rst, consumed, idx, r, p;
    int c, rdy_at, fin_at, last_rdy, first_rd, first_rn, first_rst, done_at, err_at;
    bit holding;
    logic [DW-1:0] held_r, held_v;
    pkgs  = (total + N - 1) / N;
    pk    = (pkgs == 0) ? 1 : pkgs;
    n_exp = (total == 0 || rows == 0) ? 0 : pkgs * rows;
    n_rd = 0; n_rn = 0; n_rst = 0; consumed = 0;
    rdy_at = -1; fin_at = -1; last_rdy = -1; first_rd = -1; first_rn = -1; first_rst = -1;
    done_at = -1; err_at = -1; holding = 1'b0; held_r = '0; held_v = '0;
    salt_r = $urandom; salt_v = $urandom;
    @(negedge clk);
    total_i = total; num_rows_i = 16'(rows); row_base_i = rbase; vec_base_i = vbase;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_clears_error", DW'(error), DW'(0));
    if (n_exp > 0) check("busy_after_start", DW'(busy), DW'(1));
    for (c = 1; c < 3000 && done_at < 0 && err_at < 0; c++) begin
      dp_ready_i = 1'b0; dp_finish_i = 1'b0;
      if (dp_reset) begin
        if (first_rst < 0) first_rst = c;
        check("rst_row_index", DW'(row_index), DW'(n_rst));
        n_rst++;
      end
      if (row_rd_en) begin
        if (first_rd < 0) first_rd = c;
        idx = n_rd; r = idx / pk; p = idx % pk;
        check("row_addr", DW'(row_addr), DW'(16'(32'(rbase) + r * pkgs + p)));
        check("vec_addr", DW'(vec_addr), DW'(16'(32'(vbase) + p)));
        check("vec_rd_en", DW'(vec_rd_en), DW'(1));
        n_rd++;
      end
      if (read_now) begin
        if (first_rn < 0) first_rn = c;
        idx = n_rn; r = idx / pk; p = idx % pk;
        check("first_row_out", first_out,
              exp_pkg(mem_word(16'(32'(rbase) + r * pkgs + p), salt_r), total, p));
        check("second_row_out", second_out, exp_pkg(mem_word(16'(32'(vbase) + p), salt_v), total, p));
        check("row_index", DW'(row_index), DW'(r));
        if (last_rdy >= 0 && consumed != 0) check("pkg_gap", DW'(c - last_rdy), DW'(3));
        n_rn++;
        holding = 1'b1; held_r = first_out; held_v = second_out;
        rdy_at = no_ready ? -1 : c + int'($urandom_range(1, max_dly));
        if (spurious) dp_ready_i = 1'b1;
      end else if (holding) begin
        check("hold_first", first_out, held_r);
        check("hold_second", second_out, held_v);
      end
      if (c == rdy_at) begin
        dp_ready_i = 1'b1; last_rdy = c; consumed++;
        if (consumed == pkgs) begin
          consumed = 0;
          fin_at = c + int'($urandom_range(1, max_dly));
        end
      end
      if (c == fin_at) dp_finish_i = 1'b1;
      if (done) done_at = c;
      if (error) begin
        err_at = c;
        check("busy_on_error", DW'(busy), DW'(0));
      end
      if (done_at < 0 && err_at < 0) @(negedge clk);
    end
    dp_ready_i = 1'b0; dp_finish_i = 1'b0;
    if (no_ready) begin
      check("timeout_cycle", DW'(err_at), DW'(first_rn + TMO + 1));
      check("no_done_on_timeout", DW'(done_at), DW'(-1));
    end else begin
      check("done_seen", DW'(done_at > 0), DW'(1));
      check("rd_count", DW'(n_rd), DW'(n_exp));
      check("read_now_count", DW'(n_rn), DW'(n_exp));
      check("dp_reset_count", DW'(n_rst), DW'((n_exp > 0) ? rows : 0));
      check("error_clear", DW'(error), DW'(0));
      if (n_exp == 0) begin
        check("zero_done_at_t1", DW'(done_at), DW'(1));
      end else begin
        check("dp_reset_at_t1", DW'(first_rst), DW'(1));
        check("rd_en_at_t2", DW'(first_rd), DW'(2));
        check("read_now_at_t4", DW'(first_rn), DW'(4));
        check("done_after_finish", DW'(done_at), DW'(fin_at + 1));
      end
    end
    @(negedge clk);
    check("idle_busy", DW'(busy), DW'(0));
    check("idle_done", DW'(done), DW'(0));
    check("error_sticky", DW'(error), DW'(no_ready));
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; total_i = '0; num_rows_i = '0;
    row_base_i = '0; vec_base_i = '0; dp_ready_i = 1'b0; dp_finish_i = 1'b0;
    salt_r = 0; salt_v = 0;
    repeat (3) @(negedge clk);
    check("reset_data", first_out | second_out, DW'(0));
    check("reset_ctrl", DW'({row_rd_en, row_addr, vec_rd_en, vec_addr, read_now, dp_reset,
                             busy, row_index, done, error}), DW'(0));
    reset = 1'b0;

    run_job(8, 1, 16'h0040, 16'h0200, 1, 1'b0, 1'b0);
    run_job(20, 1, 16'h0010, 16'h0300, 2, 1'b0, 1'b0);
    run_job(16, 3, 16'h0100, 16'h0020, 2, 1'b0, 1'b0);
    run_job(24, 2, 16'h0500, 16'h0600, 5, 1'b1, 1'b0);
    run_job(0, 3, 16'h0001, 16'h0002, 1, 1'b0, 1'b0);
    run_job(13, 0, 16'h0001, 16'h0002, 1, 1'b0, 1'b0);
    run_job(16, 1, 16'h0700, 16'h0800, 1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_job($urandom_range(1, 40), $urandom_range(1, 3), 16'($urandom_range(16'hFFF0, 16'hFFFF)),
              16'($urandom), $urandom_range(1, 4), 1'($urandom), 1'b0);
    end

    // Reset in the middle of WAIT_RDY must clear every output on the next cycle.
    @(negedge clk);
    total_i = 16; num_rows_i = 2; row_base_i = 16'h1234; vec_base_i = 16'h4321; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 20 && !read_now; c++) @(negedge clk);
    check("reach_read_now", DW'(read_now), DW'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_data", first_out | second_out, DW'(0));
    check("midrun_reset_ctrl", DW'({row_rd_en, row_addr, vec_rd_en, vec_addr, read_now,
                                    dp_reset, busy, row_index, done, error}), DW'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
